// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - issue scheduler and result router for the shared F pipeline
// Define PIPE_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pipe_sched #(
  parameter int N   = 10,
  parameter int NR  = 4,
  parameter int LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NR-1:0]           req,
  input  logic [NR*N-1:0]         ops_a,
  input  logic [NR*N-1:0]         ops_b,
  input  logic [NR*N-1:0]         ops_c,
  input  logic [NR*N-1:0]         ops_d,
  output logic [NR-1:0]           gnt,
  output logic [N-1:0]            pipe_a,
  output logic [N-1:0]            pipe_b,
  output logic [N-1:0]            pipe_c,
  output logic [N-1:0]            pipe_d,
  output logic                    issue_vld,
  input  logic [N-1:0]            pipe_f,
  output logic                    res_vld,
  output logic [$clog2(NR)-1:0]   res_id,
  output logic [N-1:0]            res_data,
  output logic [NR-1:0]           busy,
  input  logic                    drain,
  output logic                    idle
);
  localparam int IW = $clog2(NR);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [NR-1:0] busy_q, busy_d, elig;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [N-1:0]  pa_q, pb_q, pc_q, pd_q;
  logic          issue_vld_q, idle_q;
  logic [IW-1:0] issue_id_q;
  logic [LAT-1:0] tag_vld_q;
  logic [IW-1:0] tag_id_q [LAT];

  assign elig = req & ~busy_q & {NR{rst_n && (state_q == S_RUN)}};

`ifdef PIPE_SCHED_FIXED_PRIO_EN
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (elig[IW'(i)]) begin
        win     = IW'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;
  int            idx;

  // Scan farthest-first so the candidate nearest to ptr_q+1 is the last to win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NR; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NR;
      if (elig[IW'(idx)]) begin
        win     = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IW'(NR - 1);
    end else if (win_vld) begin
      ptr_q <= win;
    end
  end
`endif

  assign gnt = win_vld ? (NR'(1) << win) : '0;

  always_comb begin
    busy_d = busy_q;
    if (tag_vld_q[LAT-1]) busy_d[tag_id_q[LAT-1]] = 1'b0;
    if (win_vld) busy_d[win] = 1'b1;
  end

  // Every in-flight op holds its requester's busy bit, so busy_d==0 means the pipe is empty after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (drain) state_d = S_DRAIN;
      S_DRAIN: if (!drain) state_d = S_RUN;
               else if (busy_d == '0) state_d = S_HALT;
      S_HALT:  if (!drain) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      busy_q      <= '0;
      idle_q      <= 1'b0;
      pa_q        <= '0;
      pb_q        <= '0;
      pc_q        <= '0;
      pd_q        <= '0;
      issue_vld_q <= 1'b0;
      issue_id_q  <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      idle_q      <= (state_d == S_HALT);
      issue_vld_q <= win_vld;
      if (win_vld) begin
        pa_q       <= ops_a[win*N +: N];
        pb_q       <= ops_b[win*N +: N];
        pc_q       <= ops_c[win*N +: N];
        pd_q       <= ops_d[win*N +: N];
        issue_id_q <= win;
      end
      tag_vld_q[0] <= issue_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign pipe_a    = pa_q;
  assign pipe_b    = pb_q;
  assign pipe_c    = pc_q;
  assign pipe_d    = pd_q;
  assign issue_vld = issue_vld_q;
  assign res_vld   = tag_vld_q[LAT-1];
  assign res_id    = tag_id_q[LAT-1];
  assign res_data  = pipe_f;
  assign busy      = busy_q;
  assign idle      = idle_q;

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Issue scheduler and result router for the shared 3-stage arithmetic pipeline computing F = ((A+B)+(C-D))*D. It arbitrates among NR requesters and registers the winner's operand set into the pipeline. It tracks each in-flight operation with a valid/ID shift register matched to pipeline latency, then returns the pipeline result to the originating requester. It allows one outstanding operation per requester and supports drain-to-idle for reconfiguration or power-down.

## Interface
- N, 10, operand/result width (matches pipeline N)
- NR, 4, number of requesters (2..8)
- LAT, 3, pipeline register depth, operands-in to F-out, in cycles
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous reset, active-low
- req  in  NR  per-requester request, held until granted
- ops_a, ops_b, ops_c, ops_d  in  NR*N each  packed operands; requester i owns bits [i*N +: N]
- gnt  out  NR  one-hot grant, combinational, asserted in the cycle operands are sampled
- pipe_a, pipe_b, pipe_c, pipe_d  out  N each  registered operands to pipeline A/B/C/D
- issue_vld  out  1  registered; pipe_* carry a real operation this cycle
- pipe_f  in  N  pipeline result F
- res_vld  out  1  result valid this cycle
- res_id  out  $clog2(NR)  requester owning res_data
- res_data  out  N  result; equals pipe_f
- busy  out  NR  per-requester outstanding flag
- drain  in  1  stop issuing and empty pipeline
- idle  out  1  drained, no operations in flight

## Operation
- Eligibility: req[i] & ~busy[i] & (state==RUN).
- Arbitration: round-robin. Search starts at last granted index + 1 and wraps at NR-1 → 0. The pointer updates only on a grant. At most one gnt bit per cycle.
- On a grant edge: pipe_* ← ops of the winner, issue_vld ← 1, busy[winner] ← 1, tag stage 0 ← {1, winner}. With no grant, issue_vld ← 0 and pipe_* hold their values.
- Tag pipe: LAT stages of {vld, id} shift every cycle behind issue_vld. The last stage drives res_vld/res_id.
- Result: when res_vld=1, busy[res_id] clears at the end of that cycle. No bypass, so requester i is not eligible again in its own result cycle.
- Requester handshake: the requester keeps req and ops stable until it sees gnt. It must accept the result unconditionally; there is no result backpressure.
- Arithmetic: none in this block. Widths pass through, and truncation mod 2^N is the pipeline's job.
- FSM:
  - RUN: drain=1 → DRAIN.
  - DRAIN: no grants. drain=0 → RUN. busy==0 and all tag valids 0 → HALT.
  - HALT: idle=1, no grants. drain=0 → RUN.
  - Reset → RUN.
- Simultaneous result and request from the same requester: the result retires, and the request waits one cycle.
- drain asserted in the same cycle as an eligible request: the grant is still given in that cycle, because state is still RUN. DRAIN takes effect from the next cycle.
- Reset mid-operation: busy, tag valids, issue_vld and res_vld all clear. In-flight pipeline data is discarded; the pipeline has no reset, and its output is masked by the tag valids.

## Timing
- Grant in cycle t → issue_vld/pipe_* valid in t+1 → res_vld in t+1+LAT (t+4 at default).
- Throughput: one issue per cycle across requesters. Per requester, one issue per LAT+2 cycles.
- Reset values:
  - gnt = 0, issue_vld = 0, pipe_* = 0, res_vld = 0, res_id = 0, busy = 0, idle = 0.
  - RR pointer = NR-1, so requester 0 wins first.
  - State = RUN.
- idle is registered and asserts the cycle after entry to HALT; it deasserts the cycle after leaving HALT.

## Configuration
- PIPE_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest eligible index wins, RR pointer removed.
- PIPE_SCHED_FIXED_PRIO_EN undefined: round-robin as above.
- All other behaviour is identical in both modes.

## Test plan
- Single op: req[2]=1 with A=5, B=3, C=9, D=2 at t → gnt=4'b0100 at t, issue_vld at t+1, res_vld=1 with res_id=2 and res_data=30 at t+4, busy[2] high during t+1..t+4.
- Round-robin: req=4'b1111 held from reset → grants in order 0,1,2,3 on consecutive cycles, then none until busy clears. Under PIPE_SCHED_FIXED_PRIO_EN the same grant order, but re-grant of requester 0 precedes 1 once both are free.
- One outstanding: req[0] held continuously → grants at t and t+5 only; no grant to 0 in its result cycle t+4.
- Drain: issue 3 ops, assert drain → no further gnt, all 3 results return, idle=1 one cycle after the last res_vld. Deassert drain → grants resume the next cycle.
- Reset mid-flight: rst_n low for 1 cycle, 2 cycles after two grants → res_vld never asserts for those ops, busy=0, and a new request is granted the cycle after reset release.
- Width wrap (N=10): A=1023, B=1, C=0, D=1 → res_data = ((0)+(1023))*1 mod 1024 = 1023.
